// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the word-access data memory.
// Define DMEM_ARB_RR_EN for round-robin ties; otherwise port 0 has fixed priority.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  output logic              ack0_o,
  output logic [DATA_W-1:0] rdata0_o,

  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic              ack1_o,
  output logic [DATA_W-1:0] rdata1_o,

  output logic              busy_o,

  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              mem_write_o,
  output logic              mem_read_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               gnt_q;
  logic               we_q;
  logic               last_grant_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata0_q, rdata1_q;

  logic               any_req;
  logic               win;
  logic               resp_live;

  assign any_req = req0_i | req1_i;

  // Winner index: a lone requester always wins; ties are resolved by policy.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    win = ~req0_i;
    if (req0_i && req1_i) begin
`ifdef DMEM_ARB_RR_EN
      win = ~last_grant_q;
`else
      win = 1'b0;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_i) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request fields are latched once at grant, so requesters may drop them early.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_grant_q <= 1'b1;
    end else begin
      if (state_q == IDLE && any_req) begin
        gnt_q   <= win;
        we_q    <= win ? we1_i    : we0_i;
        addr_q  <= win ? addr1_i  : addr0_i;
        wdata_q <= win ? wdata1_i : wdata0_i;
      end
      if (state_q == RESP) last_grant_q <= gnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (state_q == RESP && !we_q) begin
      if (gnt_q) rdata1_q <= mem_rdata_i;
      else       rdata0_q <= mem_rdata_i;
    end
  end

  // The memory output is only valid during RESP, so the ack cycle forwards it
  // directly; the held copy takes over from the next cycle.
  assign resp_live = (state_q == RESP) && rst_i;

  assign ack0_o   = resp_live && !gnt_q;
  assign ack1_o   = resp_live &&  gnt_q;
  assign rdata0_o = (ack0_o && !we_q) ? mem_rdata_i : rdata0_q;
  assign rdata1_o = (ack1_o && !we_q) ? mem_rdata_i : rdata1_q;

  assign busy_o      = (state_q != IDLE);
  assign mem_addr_o  = addr_q;
  assign mem_data_o  = wdata_q;
  assign mem_write_o = (state_q == ACCESS) &&  we_q;
  assign mem_read_o  = (state_q == ACCESS) && !we_q;

`ifndef SYNTHESIS
  a_strobe_excl: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(mem_write_o && mem_read_o));
  a_ack_excl: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(ack0_o && ack1_o));
  a_access_one_cycle: assert property (@(posedge clk_i) disable iff (!rst_i)
    (state_q == ACCESS) |=> (state_q != ACCESS));
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed transfers push expected acks,
// a negedge monitor pops and compares them against the DUT.
module tb_dmem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req0_i, we0_i, req1_i, we1_i;
  logic [31:0] addr0_i, wdata0_i, addr1_i, wdata1_i;
  logic        ack0_o, ack1_o, busy_o, mem_write_o, mem_read_o;
  logic [31:0] rdata0_o, rdata1_o, mem_addr_o, mem_data_o;
  logic [31:0] mem_rdata_i = '0;

  typedef struct {
    bit          port;
    bit          is_read;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   wr_cnt = 0;
  logic [31:0] mem [0:63];

  dmem_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_i(req0_i), .we0_i(we0_i), .addr0_i(addr0_i), .wdata0_i(wdata0_i),
    .ack0_o(ack0_o), .rdata0_o(rdata0_o),
    .req1_i(req1_i), .we1_i(we1_i), .addr1_i(addr1_i), .wdata1_i(wdata1_i),
    .ack1_o(ack1_o), .rdata1_o(rdata1_o),
    .busy_o(busy_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_write_o(mem_write_o), .mem_read_o(mem_read_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Memory model: no reset, registered read data.
  initial for (int i = 0; i < 64; i++) mem[i] = '0;
  always @(posedge clk_i) begin
    if (mem_write_o) mem[mem_addr_o[7:2]] <= mem_data_o;
    if (mem_read_o)  mem_rdata_i <= mem[mem_addr_o[7:2]];
  end
  always @(negedge clk_i) if (mem_write_o === 1'b1) wr_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  exp_t e;
  always @(negedge clk_i) begin
    if (ack0_o === 1'b1 || ack1_o === 1'b1) begin
      check("ack_onehot", {31'b0, ack0_o & ack1_o}, 32'd0);
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_ack: ack0=%b ack1=%b expected none (cycle %0d)", ack0_o, ack1_o, cyc);
      end else begin
        e = sb.pop_front();
        check("ack_port", {31'b0, ack1_o}, {31'b0, e.port});
        check("ack_cycle", cyc, e.cyc);
        if (e.is_read) check("ack_rdata", e.port ? rdata1_o : rdata0_o, e.rdata);
      end
    end
  end

  task automatic push_exp(input bit port, input bit is_read, input logic [31:0] rdata, input int at);
    exp_t x;
    x.port = port; x.is_read = is_read; x.rdata = rdata; x.cyc = at;
    sb.push_back(x);
  endtask

  // Entered just after a rising edge with the DUT in IDLE; leaves one IDLE cycle later.
  task automatic xfer(input bit port, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input bit drop_early);
    push_exp(port, !we, exp_rdata, cyc + 2);
    if (port) begin req1_i = 1'b1; we1_i = we; addr1_i = addr; wdata1_i = wdata; end
    else      begin req0_i = 1'b1; we0_i = we; addr0_i = addr; wdata0_i = wdata; end
    @(posedge clk_i); #1;
    if (drop_early) begin req0_i = 1'b0; req1_i = 1'b0; end
    @(negedge clk_i);
    check("busy_access", {31'b0, busy_o}, 32'd1);
    check("strobe", {30'b0, mem_write_o, mem_read_o}, we ? 32'd2 : 32'd1);
    check("mem_addr", mem_addr_o, addr);
    if (we) check("mem_data", mem_data_o, wdata);
    @(posedge clk_i); #1;
    req0_i = 1'b0; req1_i = 1'b0;
    @(negedge clk_i);
    check("busy_resp", {31'b0, busy_o}, 32'd1);
    @(posedge clk_i); #1;
  endtask

  initial begin
    int w0;
    rst_i = 1'b0;
    req0_i = 1'b1; we0_i = 1'b0; addr0_i = '0; wdata0_i = '0;
    req1_i = 1'b0; we1_i = 1'b0; addr1_i = '0; wdata1_i = '0;

    repeat (2) begin
      @(posedge clk_i);
      @(negedge clk_i);
      check("rst_ack", {30'b0, ack0_o, ack1_o}, 32'd0);
      check("rst_strobe", {30'b0, mem_write_o, mem_read_o}, 32'd0);
      check("rst_busy", {31'b0, busy_o}, 32'd0);
      check("rst_rdata0", rdata0_o, 32'd0);
      check("rst_rdata1", rdata1_o, 32'd0);
    end
    req0_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b1;

    w0 = wr_cnt;
    xfer(1'b0, 1'b1, 32'd8, 32'hDEADBEEF, 32'h0, 1'b0);
    check("write_pulse_count", wr_cnt - w0, 32'd1);

    xfer(1'b0, 1'b0, 32'd8, 32'h0, 32'hDEADBEEF, 1'b0);
    repeat (3) @(posedge clk_i);
    #1;
    check("rdata0_hold", rdata0_o, 32'hDEADBEEF);

    xfer(1'b1, 1'b0, 32'd8, 32'h0, 32'hDEADBEEF, 1'b0);

    // Both ports request continuously for four transactions.
`ifdef DMEM_ARB_RR_EN
    push_exp(1'b0, 1'b1, 32'hDEADBEEF, cyc + 2);
    push_exp(1'b1, 1'b1, 32'hDEADBEEF, cyc + 5);
    push_exp(1'b0, 1'b1, 32'hDEADBEEF, cyc + 8);
    push_exp(1'b1, 1'b1, 32'hDEADBEEF, cyc + 11);
`else
    push_exp(1'b0, 1'b1, 32'hDEADBEEF, cyc + 2);
    push_exp(1'b0, 1'b1, 32'hDEADBEEF, cyc + 5);
    push_exp(1'b0, 1'b1, 32'hDEADBEEF, cyc + 8);
    push_exp(1'b0, 1'b1, 32'hDEADBEEF, cyc + 11);
`endif
    req0_i = 1'b1; we0_i = 1'b0; addr0_i = 32'd8;
    req1_i = 1'b1; we1_i = 1'b0; addr1_i = 32'd8;
    repeat (11) @(posedge clk_i);
    #1;
    req0_i = 1'b0; req1_i = 1'b0;
    @(posedge clk_i); #1;

    xfer(1'b1, 1'b1, 32'd16, 32'h12345678, 32'h0, 1'b0);
    check("rdata1_after_write", rdata1_o, 32'hDEADBEEF);
    xfer(1'b0, 1'b0, 32'd16, 32'h0, 32'h12345678, 1'b0);
    check("rdata1_isolated", rdata1_o, 32'hDEADBEEF);
    xfer(1'b1, 1'b0, 32'd16, 32'h0, 32'h12345678, 1'b1);

    // Reset sampled at the end of the ACCESS cycle of a port-0 write.
    req0_i = 1'b1; we0_i = 1'b1; addr0_i = 32'd4; wdata0_i = 32'hA5A5A5A5;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    req0_i = 1'b0;
    @(negedge clk_i);
    check("midrst_strobe", {31'b0, mem_write_o}, 32'd1);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    @(negedge clk_i);
    check("midrst_ack", {30'b0, ack0_o, ack1_o}, 32'd0);
    check("midrst_busy", {31'b0, busy_o}, 32'd0);
    check("midrst_rdata0", rdata0_o, 32'd0);
    @(posedge clk_i); #1;
    xfer(1'b0, 1'b0, 32'd4, 32'h0, 32'hA5A5A5A5, 1'b0);

    repeat (4) @(posedge clk_i);
    #1;
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
